// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the writeback-stage exception controller: request bit
// indices, exception codes, register select values and CP0 field positions.
package exc_pkg;

    localparam int unsigned EXC_REQ_W   = 15;
    localparam int unsigned EXC_NUM_SRC = 14;

    // Request bit index doubles as priority rank: bit 0 is highest. Bit 14 is reserved.
    localparam int unsigned EXC_DADEL   = 0;
    localparam int unsigned EXC_DTLBL   = 1;
    localparam int unsigned EXC_DADES   = 2;
    localparam int unsigned EXC_DTLBMOD = 3;
    localparam int unsigned EXC_DTLBS   = 4;
    localparam int unsigned EXC_RI      = 5;
    localparam int unsigned EXC_CPU     = 6;
    localparam int unsigned EXC_BREAK   = 7;
    localparam int unsigned EXC_SYSCALL = 8;
    localparam int unsigned EXC_IADEL   = 9;
    localparam int unsigned EXC_ITLBL   = 10;
    localparam int unsigned EXC_IBE     = 11;
    localparam int unsigned EXC_DBE     = 12;
    localparam int unsigned EXC_OV      = 13;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcMod  = 5'd1,
        ExcTlbl = 5'd2,
        ExcTlbs = 5'd3,
        ExcAdel = 5'd4,
        ExcAdes = 5'd5,
        ExcIbe  = 5'd6,
        ExcDbe  = 5'd7,
        ExcSys  = 5'd8,
        ExcBp   = 5'd9,
        ExcRi   = 5'd10,
        ExcCpu  = 5'd11,
        ExcOv   = 5'd12
    } exc_code_e;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_EPC    = 2'd2;

    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM_LSB = 8;
    localparam int unsigned CAUSE_CODE_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB   = 8;
    localparam int unsigned CAUSE_BD       = 31;

    function automatic exc_code_e exc_code_of(input int unsigned idx);
        case (idx)
            EXC_DADEL:   return ExcAdel;
            EXC_DTLBL:   return ExcTlbl;
            EXC_DADES:   return ExcAdes;
            EXC_DTLBMOD: return ExcMod;
            EXC_DTLBS:   return ExcTlbs;
            EXC_RI:      return ExcRi;
            EXC_CPU:     return ExcCpu;
            EXC_BREAK:   return ExcBp;
            EXC_SYSCALL: return ExcSys;
            EXC_IADEL:   return ExcAdel;
            EXC_ITLBL:   return ExcTlbl;
            EXC_IBE:     return ExcIbe;
            EXC_DBE:     return ExcDbe;
            EXC_OV:      return ExcOv;
            default:     return ExcInt;
        endcase
    endfunction

    // Address-related codes (TLB and alignment faults) capture the faulting address.
    function automatic logic code_has_badvaddr(input exc_code_e code);
        return (code >= ExcMod) && (code <= ExcAdes);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline-facing bundle of the exception controller: request/control inputs
// and architectural register / redirect outputs.
interface exc_ctrl_if #(
    parameter int unsigned N_IRQ = 8
);
    import exc_pkg::*;

    logic [EXC_REQ_W-1:0] exc_req;
    logic [N_IRQ-1:0]     irq;
    logic [31:0]          pc_wb;
    logic                 delay_slot;
    logic [31:0]          badvaddr_in;
    logic                 eret;
    logic                 mtc0_we;
    logic [1:0]           mtc0_sel;
    logic [31:0]          mtc0_data;
    logic [31:0]          status;
    logic [31:0]          cause;
    logic [31:0]          epc;
    logic [31:0]          badvaddr;
    logic                 e_enter;
    logic                 flush;
    logic [31:0]          vector;

    modport master (
        output exc_req, irq, pc_wb, delay_slot, badvaddr_in, eret,
               mtc0_we, mtc0_sel, mtc0_data,
        input  status, cause, epc, badvaddr, e_enter, flush, vector
    );

    modport slave (
        input  exc_req, irq, pc_wb, delay_slot, badvaddr_in, eret,
               mtc0_we, mtc0_sel, mtc0_data,
        output status, cause, epc, badvaddr, e_enter, flush, vector
    );

endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Fixed-priority encoder over the synchronous exception flags; lowest set
// index wins and is translated to its ExcCode.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [EXC_REQ_W-1:0] req,
    output logic                 valid,
    output exc_code_e            code
);

    logic unused_reserved;
    assign unused_reserved = ^req[EXC_REQ_W-1:EXC_NUM_SRC];

    always_comb begin
        valid = 1'b0;
        code  = ExcInt;
        // Scan downward so the highest-priority (lowest) index is assigned last.
        for (int i = EXC_NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                code  = exc_code_of(i);
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Writeback-boundary exception/interrupt controller: holds Status, Cause, EPC,
// BadVAddr and the interrupt-pending register, and drives the pipeline redirect.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_IRQ       = 8,
    parameter logic [31:0] VEC_RESET   = 32'h8000_0100,
    parameter logic [31:0] VEC_GENERAL = 32'h8000_0000,
    parameter logic [31:0] VEC_IRQ     = 32'h8000_0200
) (
    input logic       clk,
    input logic       reset,
    exc_ctrl_if.slave bus
);

    logic             ie_q, ie_d;
    logic             exl_q, exl_d;
    logic [N_IRQ-1:0] im_q, im_d;
    logic             bd_q, bd_d;
    exc_code_e        code_q, code_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [N_IRQ-1:0] ip_q;

    logic      sync_valid;
    exc_code_e sync_code;
    logic      irq_take;
    logic      take;
    logic      eret_take;
    exc_code_e take_code;

    exc_prio_enc u_prio_enc (
        .req   (bus.exc_req),
        .valid (sync_valid),
        .code  (sync_code)
    );

    assign irq_take  = !sync_valid && ie_q && !exl_q && |(ip_q & im_q);
    assign take      = sync_valid || irq_take;
    assign eret_take = bus.eret && !take;
    assign take_code = sync_valid ? sync_code : ExcInt;

    // Redirect outputs
    always_comb begin
        bus.e_enter = 1'b0;
        bus.flush   = 1'b0;
        bus.vector  = '0;
        if (reset) begin
            bus.e_enter = 1'b1;
            bus.flush   = 1'b1;
            bus.vector  = VEC_RESET;
        end else if (take) begin
            bus.e_enter = 1'b1;
            bus.flush   = 1'b1;
            bus.vector  = sync_valid ? VEC_GENERAL : VEC_IRQ;
        end else if (eret_take) begin
            bus.flush  = 1'b1;
            bus.vector = epc_q;
        end
    end

    // Next state: software writes first, then hardware events override per register.
    always_comb begin
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        bd_d       = bd_q;
        code_d     = code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (bus.mtc0_we) begin
            unique case (bus.mtc0_sel)
                SEL_STATUS: begin
                    if (!take && !eret_take) begin
                        ie_d  = bus.mtc0_data[STATUS_IE];
                        exl_d = bus.mtc0_data[STATUS_EXL];
                        im_d  = bus.mtc0_data[STATUS_IM_LSB +: N_IRQ];
                    end
                end
                SEL_CAUSE: begin
                    if (!take) bd_d = bus.mtc0_data[CAUSE_BD];
                end
                SEL_EPC: begin
                    // A nested entry leaves EPC alone, so the write still lands.
                    if (!take || exl_q) epc_d = bus.mtc0_data;
                end
                default: ;
            endcase
        end

        if (take) begin
            exl_d  = 1'b1;
            code_d = take_code;
            if (!exl_q) begin
                epc_d = bus.delay_slot ? bus.pc_wb - 32'd4 : bus.pc_wb;
                bd_d  = bus.delay_slot;
            end
            if (sync_valid && code_has_badvaddr(sync_code)) badvaddr_d = bus.badvaddr_in;
        end else if (eret_take) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            bd_q       <= 1'b0;
            code_q     <= ExcInt;
            epc_q      <= '0;
            badvaddr_q <= '0;
            ip_q       <= '0;
        end else begin
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            bd_q       <= bd_d;
            code_q     <= code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            ip_q       <= bus.irq;
        end
    end

    always_comb begin
        bus.status                             = '0;
        bus.status[STATUS_IE]                  = ie_q;
        bus.status[STATUS_EXL]                 = exl_q;
        bus.status[STATUS_IM_LSB +: N_IRQ]     = im_q;
        bus.cause                              = '0;
        bus.cause[CAUSE_BD]                    = bd_q;
        bus.cause[CAUSE_IP_LSB +: N_IRQ]       = ip_q;
        bus.cause[CAUSE_CODE_LSB +: 5]         = code_q;
    end

    assign bus.epc      = epc_q;
    assign bus.badvaddr = badvaddr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl: reset, priority/delay slot, nesting,
// ERET, interrupt gating and MTC0 collisions.
module tb_exc_ctrl;
    import exc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exc_ctrl_if #(.N_IRQ(8)) bus ();

    exc_ctrl #(
        .N_IRQ       (8),
        .VEC_RESET   (32'h8000_0100),
        .VEC_GENERAL (32'h8000_0000),
        .VEC_IRQ     (32'h8000_0200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle();
        bus.exc_req     = '0;
        bus.pc_wb       = '0;
        bus.delay_slot  = 1'b0;
        bus.badvaddr_in = '0;
        bus.eret        = 1'b0;
        bus.mtc0_we     = 1'b0;
        bus.mtc0_sel    = '0;
        bus.mtc0_data   = '0;
    endtask

    // Advance one clock edge and land 1ns after it, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [1:0] sel, input logic [31:0] data);
        idle();
        bus.mtc0_we   = 1'b1;
        bus.mtc0_sel  = sel;
        bus.mtc0_data = data;
        step();
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.irq = '0;
        reset = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL rst_flush got %b exp 1", bus.flush); end
        checks++; if (bus.vector !== 32'h8000_0100) begin failures++; $display("FAIL rst_vector got %h exp 80000100", bus.vector); end
        checks++; if (bus.e_enter !== 1'b1) begin failures++; $display("FAIL rst_e_enter got %b exp 1", bus.e_enter); end
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.status !== 32'h0) begin failures++; $display("FAIL rst_status got %h exp 0", bus.status); end
        checks++; if (bus.cause !== 32'h0) begin failures++; $display("FAIL rst_cause got %h exp 0", bus.cause); end
        checks++; if (bus.epc !== 32'h0) begin failures++; $display("FAIL rst_epc got %h exp 0", bus.epc); end
        checks++; if (bus.badvaddr !== 32'h0) begin failures++; $display("FAIL rst_badvaddr got %h exp 0", bus.badvaddr); end
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL rst_release_flush got %b exp 0", bus.flush); end
    endtask

    task automatic test_priority();
        idle();
        bus.exc_req[EXC_DTLBS] = 1'b1;
        bus.exc_req[EXC_OV]    = 1'b1;
        bus.pc_wb       = 32'h8000_1000;
        bus.delay_slot  = 1'b1;
        bus.badvaddr_in = 32'hDEAD_BEE0;
        #1;
        checks++; if (bus.vector !== 32'h8000_0000) begin failures++; $display("FAIL prio_vector got %h exp 80000000", bus.vector); end
        checks++; if (bus.e_enter !== 1'b1) begin failures++; $display("FAIL prio_e_enter got %b exp 1", bus.e_enter); end
        step();
        idle();
        #1;
        checks++; if (bus.cause !== 32'h8000_000C) begin failures++; $display("FAIL prio_cause got %h exp 8000000c", bus.cause); end
        checks++; if (bus.epc !== 32'h8000_0FFC) begin failures++; $display("FAIL prio_epc got %h exp 80000ffc", bus.epc); end
        checks++; if (bus.status !== 32'h0000_0002) begin failures++; $display("FAIL prio_status got %h exp 00000002", bus.status); end
        checks++; if (bus.badvaddr !== 32'hDEAD_BEE0) begin failures++; $display("FAIL prio_badvaddr got %h exp deadbee0", bus.badvaddr); end
    endtask

    task automatic test_nested();
        idle();
        bus.exc_req[EXC_SYSCALL] = 1'b1;
        bus.pc_wb       = 32'h8000_2000;
        bus.badvaddr_in = 32'h1234_5678;
        #1;
        checks++; if (bus.vector !== 32'h8000_0000) begin failures++; $display("FAIL nest_vector got %h exp 80000000", bus.vector); end
        step();
        idle();
        #1;
        checks++; if (bus.epc !== 32'h8000_0FFC) begin failures++; $display("FAIL nest_epc got %h exp 80000ffc", bus.epc); end
        checks++; if (bus.cause !== 32'h8000_0020) begin failures++; $display("FAIL nest_cause got %h exp 80000020", bus.cause); end
        checks++; if (bus.badvaddr !== 32'hDEAD_BEE0) begin failures++; $display("FAIL nest_badvaddr got %h exp deadbee0", bus.badvaddr); end
    endtask

    task automatic test_eret();
        mtc0(SEL_EPC, 32'h8000_0400);
        checks++; if (bus.epc !== 32'h8000_0400) begin failures++; $display("FAIL eret_epc_wr got %h exp 80000400", bus.epc); end
        bus.eret = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL eret_flush got %b exp 1", bus.flush); end
        checks++; if (bus.vector !== 32'h8000_0400) begin failures++; $display("FAIL eret_vector got %h exp 80000400", bus.vector); end
        checks++; if (bus.e_enter !== 1'b0) begin failures++; $display("FAIL eret_e_enter got %b exp 0", bus.e_enter); end
        step();
        idle();
        #1;
        checks++; if (bus.status !== 32'h0) begin failures++; $display("FAIL eret_status got %h exp 0", bus.status); end
        mtc0(SEL_STATUS, 32'h0000_0002);
        bus.eret = 1'b1;
        bus.exc_req[EXC_RI] = 1'b1;
        bus.pc_wb = 32'h8000_7000;
        #1;
        checks++; if (bus.vector !== 32'h8000_0000) begin failures++; $display("FAIL eret_ri_vector got %h exp 80000000", bus.vector); end
        checks++; if (bus.e_enter !== 1'b1) begin failures++; $display("FAIL eret_ri_e_enter got %b exp 1", bus.e_enter); end
        step();
        idle();
        #1;
        checks++; if (bus.status !== 32'h0000_0002) begin failures++; $display("FAIL eret_ri_status got %h exp 00000002", bus.status); end
        checks++; if (bus.cause !== 32'h8000_0028) begin failures++; $display("FAIL eret_ri_cause got %h exp 80000028", bus.cause); end
        checks++; if (bus.epc !== 32'h8000_0400) begin failures++; $display("FAIL eret_ri_epc got %h exp 80000400", bus.epc); end
    endtask

    task automatic test_irq();
        mtc0(SEL_STATUS, 32'h0000_0401);
        bus.irq   = 8'h04;
        bus.pc_wb = 32'h8000_3000;
        #1;
        checks++; if (bus.e_enter !== 1'b0) begin failures++; $display("FAIL irq_same_cycle got %b exp 0", bus.e_enter); end
        step();
        checks++; if (bus.e_enter !== 1'b1) begin failures++; $display("FAIL irq_e_enter got %b exp 1", bus.e_enter); end
        checks++; if (bus.vector !== 32'h8000_0200) begin failures++; $display("FAIL irq_vector got %h exp 80000200", bus.vector); end
        checks++; if (bus.cause !== 32'h8000_0428) begin failures++; $display("FAIL irq_ip got %h exp 80000428", bus.cause); end
        step();
        checks++; if (bus.status !== 32'h0000_0403) begin failures++; $display("FAIL irq_status got %h exp 00000403", bus.status); end
        checks++; if (bus.cause !== 32'h0000_0400) begin failures++; $display("FAIL irq_cause got %h exp 00000400", bus.cause); end
        checks++; if (bus.epc !== 32'h8000_3000) begin failures++; $display("FAIL irq_epc got %h exp 80003000", bus.epc); end
        checks++; if (bus.e_enter !== 1'b0) begin failures++; $display("FAIL irq_exl_mask got %b exp 0", bus.e_enter); end
        mtc0(SEL_STATUS, 32'h0000_0001);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.e_enter !== 1'b0) begin failures++; $display("FAIL irq_im_zero got %b exp 0", bus.e_enter); end
            step();
        end
        bus.irq = '0;
        step();
        checks++; if (bus.cause !== 32'h0) begin failures++; $display("FAIL irq_drop got %h exp 0", bus.cause); end
    endtask

    task automatic test_mtc0();
        idle();
        bus.exc_req[EXC_OV] = 1'b1;
        bus.pc_wb     = 32'h8000_5000;
        bus.mtc0_we   = 1'b1;
        bus.mtc0_sel  = SEL_EPC;
        bus.mtc0_data = 32'h1111_1111;
        step();
        idle();
        #1;
        checks++; if (bus.epc !== 32'h8000_5000) begin failures++; $display("FAIL mtc0_epc_coll got %h exp 80005000", bus.epc); end
        checks++; if (bus.cause !== 32'h0000_0030) begin failures++; $display("FAIL mtc0_coll_cause got %h exp 00000030", bus.cause); end
        checks++; if (bus.badvaddr !== 32'hDEAD_BEE0) begin failures++; $display("FAIL mtc0_ov_badvaddr got %h exp deadbee0", bus.badvaddr); end
        mtc0(SEL_STATUS, 32'hFFFF_FFFF);
        checks++; if (bus.status !== 32'h0000_FF03) begin failures++; $display("FAIL mtc0_status got %h exp 0000ff03", bus.status); end
        mtc0(SEL_CAUSE, 32'hFFFF_FFFF);
        checks++; if (bus.cause !== 32'h8000_0030) begin failures++; $display("FAIL mtc0_cause got %h exp 80000030", bus.cause); end
        mtc0(SEL_STATUS, 32'h0);
        bus.exc_req[EXC_DADEL] = 1'b1;
        bus.pc_wb       = 32'h0;
        bus.delay_slot  = 1'b1;
        bus.badvaddr_in = 32'h0000_ABCD;
        step();
        idle();
        #1;
        checks++; if (bus.epc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_epc got %h exp fffffffc", bus.epc); end
        checks++; if (bus.cause !== 32'h8000_0010) begin failures++; $display("FAIL wrap_cause got %h exp 80000010", bus.cause); end
        checks++; if (bus.badvaddr !== 32'h0000_ABCD) begin failures++; $display("FAIL wrap_badvaddr got %h exp 0000abcd", bus.badvaddr); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_nested();
        test_eret();
        test_irq();
        test_mtc0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
